or1200_secure_supv_enc: RTL

- Encoder and owner of the redundant supervisor-mode word `secure_supv[2:0]`; downstream privilege checkers decode supv as XOR of the three bits.
- Keeps a shadow SM/ESR-SM pair, updated from the same exception, rfe and SR-write events as the OR1200 SR.
- Re-randomises the encoding every cycle so that a stuck or forced word is detectable.
- Cross-checks the shadow against the core's SR[SM] and raises a sticky tamper alarm. Sits beside or1200_sprs/or1200_except in or1200_cpu.

---
 rtl/or1200_secure_supv_enc_pkg.sv | 20 ++
 rtl/or1200_supv_lfsr.sv | 21 ++
 rtl/or1200_secure_supv_enc.sv | 84 ++++++++
 3 files changed

// File: rtl/or1200_secure_supv_enc_pkg.sv
// Shared definitions for the redundant supervisor-mode encoding: LFSR shape,
// default seed and the (supv, mask) -> 3-bit word helper used by checkers.
package or1200_secure_supv_enc_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 2;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'h13;

  typedef enum logic {
    MODE_USER = 1'b0,
    MODE_SUPV = 1'b1
  } mode_e;

  // Two mask bits travel in the clear; the third bit makes the XOR equal supv.
  function automatic logic [2:0] supv_encode(input logic supv, input logic [1:0] mask);
    return {mask[1], mask[0], supv ^ mask[1] ^ mask[0]};
  endfunction

endpackage

// File: rtl/or1200_supv_lfsr.sv
// Free-running 5-bit mask generator; an all-zero state is treated as
// corruption and reloads the seed on the next edge.
module or1200_supv_lfsr
  import or1200_secure_supv_enc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  output logic              reload,
  output logic [LFSR_W-1:0] state
);

  assign reload = (state == '0);

  always_ff @(posedge clk) begin
    if (rst || reload) state <= SEED;
    else               state <= {state[LFSR_W-2:0], state[TAP_HI] ^ state[TAP_LO]};
  end

endmodule

// File: rtl/or1200_secure_supv_enc.sv
// Shadow SM/ESR-SM tracker that publishes supervisor mode as a re-masked
// 3-bit word and raises a sticky tamper alarm on any inconsistency.
module or1200_secure_supv_enc
  import or1200_secure_supv_enc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED      = DEFAULT_SEED,
  parameter int                MISMATCH_LIMIT = 3,
  parameter int                CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except_start,
  input  logic             rfe,
  input  logic             sr_we,
  input  logic             sr_sm_in,
  input  logic             esr_sm,
  input  logic             sr_sm,
  output logic [2:0]       secure_supv,
  output logic             supv_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             tamper_alarm
);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (MISMATCH_LIMIT < 1 || MISMATCH_LIMIT > (2**CNT_W) - 1) begin : g_bad_limit
    $error("MISMATCH_LIMIT out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MISMATCH_LIMIT);

  mode_e              s, es;
  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_reload;
  logic               mm_now;
  logic [CNT_W-1:0]   cnt_inc;

  or1200_supv_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reload (lfsr_reload),
    .state  (lfsr)
  );

  assign mm_now  = (logic'(s) != sr_sm);
  assign cnt_inc = (&mismatch_cnt) ? mismatch_cnt : mismatch_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s             <= MODE_SUPV;
      es            <= MODE_SUPV;
      supv_mismatch <= 1'b0;
      mismatch_cnt  <= '0;
      tamper_alarm  <= 1'b0;
    end else begin
      // Only the highest-priority event applies; the others are dropped silently.
      if (except_start) begin
        es <= s;
        s  <= MODE_SUPV;
      end else if (rfe) begin
        s <= es;
        if (esr_sm != logic'(es)) tamper_alarm <= 1'b1;
      end else if (sr_we) begin
        if (s == MODE_SUPV) s <= mode_e'(sr_sm_in);
        else if (sr_sm_in)  tamper_alarm <= 1'b1;
      end

      if (mm_now) begin
        supv_mismatch <= 1'b1;
        mismatch_cnt  <= cnt_inc;
        if (cnt_inc >= LIMIT) tamper_alarm <= 1'b1;
      end else begin
        supv_mismatch <= 1'b0;
        mismatch_cnt  <= '0;
      end

      if (lfsr_reload) tamper_alarm <= 1'b1;
    end
  end

  assign secure_supv = supv_encode(logic'(s), lfsr[1:0]);

endmodule
